// File: rtl/ita_package.sv
// Shared ITA definitions used by the activation output buffer.
//   N, WO           : lanes per vector and bits per lane
//   requant_oup_t   : one requantised output vector (N signed 8-bit lanes)
//   ACT_LATENCY     : cycles from issue into `activation` to its result
//   ACT_BUF_DEPTH   : default entries in the activation output FIFO
//   act_buf_entry_t : one FIFO entry (vector plus end-of-tile flag)
package ita_package;

    localparam int unsigned N  = 16;
    localparam int unsigned WO = 8;

    localparam int unsigned ACT_LATENCY   = 2;
    localparam int unsigned ACT_BUF_DEPTH = 4;

    typedef logic signed [N-1:0][WO-1:0] requant_oup_t;

    typedef struct packed {
        requant_oup_t data;
        logic         last;
    } act_buf_entry_t;

endpackage

// File: rtl/activation_out_buffer_fifo.sv
// act_buf_fifo: synchronous FIFO of act_buf_entry_t with a combinational head.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of pointers and count
//   push_i/data_i : write request and entry; accepted when not full or popping
//   pop_i         : read request; ignored when empty
//   data_o        : head entry, valid whenever empty_o is low
//   count_o, full_o, empty_o : occupancy status
module act_buf_fifo
    import ita_package::*;
#(
    parameter int unsigned DEPTH = ACT_BUF_DEPTH,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  act_buf_entry_t data_i,
    input  logic           pop_i,
    output act_buf_entry_t data_o,
    output logic [CntW-1:0] count_o,
    output logic           full_o,
    output logic           empty_o
);

    act_buf_entry_t  mem_q [DEPTH];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/activation_out_buffer.sv
// Elastic output stage behind the fixed-latency `activation` unit.
// Tracks issued vectors in flight, captures each result into a FIFO and
// streams it out on valid/ready. issue_ready_o is a credit check on
// registered state only, so no in-flight result is dropped while upstream
// honours it.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : synchronous clear of FIFO, tracker, tile counter, error
//   issue_i, issue_ready_o : upstream issue strobe and credit
//   data_i                 : result of `activation`, valid LATENCY cycles after issue
//   tile_len_i             : vectors per tile (0 treated as 1)
//   valid_o, ready_i       : output handshake
//   data_o, last_o         : head vector and its end-of-tile flag (zero when idle)
//   overflow_o             : sticky, set when a result arrives with no room
module activation_out_buffer
    import ita_package::*;
#(
    parameter int unsigned N_PE    = N,
    parameter int unsigned LATENCY = ACT_LATENCY,
    parameter int unsigned DEPTH   = ACT_BUF_DEPTH,
    parameter int unsigned TILE_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              issue_i,
    output logic              issue_ready_o,
    input  requant_oup_t      data_i,
    input  logic [TILE_W-1:0] tile_len_i,
    output logic              valid_o,
    input  logic              ready_i,
    output requant_oup_t      data_o,
    output logic              last_o,
    output logic              overflow_o
);

    localparam int unsigned FifoCntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW     = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0]  track_q, track_d;
    logic [TILE_W-1:0]   tile_cnt_q, tile_cnt_d, tile_len_eff;
    logic                overflow_q, overflow_d;
    logic                tap, pop, push_acc, is_last, fifo_full, fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    logic [SumW-1:0]     inflight;
    act_buf_entry_t      push_entry, head;

    // Oldest tracker bit marks the cycle the matching result sits on data_i.
    assign tap = track_q[LATENCY-1];

    assign tile_len_eff = (tile_len_i == '0) ? TILE_W'(1) : tile_len_i;
    assign is_last      = (tile_cnt_q == tile_len_eff - 1'b1);

    assign push_entry.data = data_i;
    assign push_entry.last = is_last;

    assign valid_o  = !fifo_empty;
    assign pop      = valid_o && ready_i;
    assign push_acc = tap && (!fifo_full || pop);

    act_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (tap),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credits count both held entries and results still inside `activation`.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + SumW'(track_q[i]);
        end
        issue_ready_o = (SumW'(fifo_count) + inflight) < SumW'(DEPTH);
    end

    always_comb begin
        track_d    = (track_q << 1) | LATENCY'(issue_i);
        tile_cnt_d = tile_cnt_q;
        overflow_d = overflow_q | (tap && fifo_full && !pop);
        if (push_acc) begin
            tile_cnt_d = is_last ? '0 : tile_cnt_q + 1'b1;
        end
        if (flush_i) begin
            track_d    = '0;
            tile_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            track_q    <= '0;
            tile_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            track_q    <= track_d;
            tile_cnt_q <= tile_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Idle outputs read as zero rather than exposing a stale storage slot.
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < N_PE; i++) begin
            data_o[i] = valid_o ? head.data[i] : '0;
        end
    end

    assign last_o     = valid_o && head.last;
    assign overflow_o = overflow_q;

endmodule

// File: doc/activation_out_buffer.md
# activation_out_buffer

Elastic output stage directly downstream of the `activation` unit. `activation` has a fixed 2-cycle latency and no stall input, so this block does three things: it tracks which issued vectors are still in flight, captures each result into a small FIFO, and presents the results on a valid/ready stream to the output controller. Back-pressure reaches upstream through a credit-style `issue_ready_o`, which guarantees that no in-flight result is ever dropped.

## Interface
Parameters:
- `N_PE`, default 16: lanes per vector (matches the `requant_oup_t` width).
- `LATENCY`, default 2: cycles from issuing a vector into `activation` to its result on `data_i`.
- `DEPTH`, default 4: FIFO entries. Must be ≥ LATENCY+2 for full throughput.
- `TILE_W`, default 8: width of the tile-length counter.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: synchronous clear of the FIFO, the in-flight tracker and the tile counter.
- `issue_i`, in, 1: upstream is issuing a vector into `activation` this cycle.
- `issue_ready_o`, out, 1: upstream may issue this cycle.
- `data_i`, in, `requant_oup_t`: output of `activation`.
- `tile_len_i`, in, TILE_W: vectors per tile. Treated as a quasi-static configuration input.
- `valid_o`, out, 1: output vector valid.
- `ready_i`, in, 1: downstream accepts.
- `data_o`, out, `requant_oup_t`: head vector.
- `last_o`, out, 1: head vector is the last vector of its tile.
- `overflow_o`, out, 1: sticky error flag.

## Operation
- In-flight tracker: a LATENCY-bit shift register of `issue_i`. Bit LATENCY-1 high means `data_i` is valid this cycle and is pushed.
- Credits:
  - `issue_ready_o = (fifo_count + inflight_count) < DEPTH`.
  - The expression depends on registered state only, with no path from `ready_i`.
  - `inflight_count` is the popcount of the tracker.
- Push: on tracker tap. The pushed entry stores `data_i` and a last flag, `last = (tile_cnt == tile_len_i-1)`.
- Tile counter:
  - Advances on each push.
  - Wraps to 0 after last.
  - `tile_len_i == 0` is treated as 1: every entry is last.
- Pop: on `valid_o && ready_i`. `data_o`/`last_o` come from the head storage register with no extra cycle.
- Push and pop in the same cycle: both happen, `fifo_count` is unchanged. This is legal when full.
- Push while full without a pop:
  - Only possible if upstream ignores `issue_ready_o`.
  - The entry is dropped, the FIFO is unchanged, and `overflow_o` is set.
  - `overflow_o` is cleared only by reset or `flush_i`.
- `flush_i`:
  - Next cycle: FIFO empty, tracker zero, `tile_cnt` zero, `overflow_o` zero.
  - An `issue_i` in the same cycle as `flush_i` is discarded.
  - `issue_ready_o` is 1 in the following cycle.
- Lane arithmetic: none. Lanes are carried bit-exact (signed 8-bit per lane).

## Timing
- Reset values:
  - `valid_o` = 0, `data_o` = 0, `last_o` = 0, `overflow_o` = 0.
  - `issue_ready_o` = 1.
  - All pointers, counts and tracker bits = 0.
- Latency:
  - `issue_i` at cycle t gives a push at t+LATENCY.
  - `valid_o` is first high at t+LATENCY+1 (3 cycles by default), provided the FIFO was empty.
- Throughput: one vector per cycle sustained when `ready_i` is held high and DEPTH ≥ LATENCY+2.
- Credit release: a pop at cycle p raises `issue_ready_o` at p+1, if that pop was the limiting credit.
- Reset mid-operation: all state clears asynchronously and in-flight results are lost. After reset deassertion, `data_i` is ignored until new issues have propagated through the tracker.
- `valid_o` stays high and `data_o`/`last_o` stay stable while `!ready_i`.

## Structure
- Shared package `ita_package`:
  - Add `ACT_LATENCY = 2` and `ACT_BUF_DEPTH = 4`.
  - Reuse `requant_oup_t`.
  - Add `act_buf_entry_t` (struct of `requant_oup_t` data plus last bit).
- Sub-module `act_buf_fifo`: a parameterised synchronous FIFO of `act_buf_entry_t` with push, pop, flush, count, full and empty.
- Top level holds the tracker, credit logic, tile counter and overflow flag.

## Test plan
- Single issue, `ready_i` = 1: `issue_i` pulse at cycle 10 with `data_i` = lanes 0..15 at cycle 12 → `valid_o` high at cycle 13 only, `data_o` = 0..15. With `tile_len_i` = 1, `last_o` = 1.
- Streaming: 64 consecutive issues, `ready_i` = 1, `tile_len_i` = 16 → 64 outputs in order on consecutive cycles, `last_o` high on outputs 15/31/47/63, `issue_ready_o` never low.
- Back-pressure: `ready_i` = 0 while issuing continuously → `issue_ready_o` drops after the 4th issue. Exactly 4 entries are held. Raising `ready_i` releases them in order with no loss.
- Full with simultaneous push and pop: FIFO full, `ready_i` = 1 in the cycle a tracked result arrives → count stays 4, output order is preserved, `overflow_o` = 0.
- Protocol violation: force `issue_i` while `issue_ready_o` = 0, with `ready_i` = 0 → the extra result is dropped and `overflow_o` sets and stays 1 until `flush_i`.
- Flush and reset: `flush_i` with 3 entries held and 2 in flight → the next cycle shows `valid_o` = 0 and `issue_ready_o` = 1, and no stale outputs appear afterward. Asserting `rst_ni` mid-stream gives the same result.
